// File: rtl/wb_stage_if.sv
// Write-back stage bus bundle.
//   master : pipeline/late-unit/hazard side driving into the stage
//   slave  : the wb_stage itself
// Groups the MEM/WB slot, the late-result handshake, the hazard query
// and the register-file write port.
interface wb_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // MEM/WB pipeline slot
  logic          wb_valid;
  logic          wb_regwrite;
  logic          wb_memtoreg;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_alu;
  logic [DW-1:0] wb_mem;
  logic [1:0]    wb_boff;
  logic [1:0]    wb_size;
  logic          wb_unsigned;
  // late result handshake
  logic          late_valid;
  logic [AW-1:0] late_waddr;
  logic [DW-1:0] late_data;
  logic          late_ready;
  // hazard query
  logic [AW-1:0] query_addr;
  logic          query_pending;
  // register-file write port
  logic          WriteReg;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wData;

  modport master (
    output wb_valid, wb_regwrite, wb_memtoreg, wb_waddr, wb_alu, wb_mem,
           wb_boff, wb_size, wb_unsigned, late_valid, late_waddr, late_data,
           query_addr,
    input  late_ready, query_pending, WriteReg, wAddr, wData
  );

  modport slave (
    input  wb_valid, wb_regwrite, wb_memtoreg, wb_waddr, wb_alu, wb_mem,
           wb_boff, wb_size, wb_unsigned, late_valid, late_waddr, late_data,
           query_addr,
    output late_ready, query_pending, WriteReg, wAddr, wData
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: drives the single register-file write port.
// Picks ALU result or extended load data for the pipeline slot, and merges
// late multi-cycle results through a small circular queue whenever the
// pipeline is not writing. Pipeline writes always win the port.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - wb_stage_if.slave (pipeline slot, late handshake, hazard query,
//          registered WriteReg/wAddr/wData)
module wb_stage #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int QDEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  wb_stage_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);

  logic          q_vld_q  [QDEPTH];
  logic [AW-1:0] q_addr_q [QDEPTH];
  logic [DW-1:0] q_data_q [QDEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;

  logic [PW:0]   occ;
  logic          full, empty, pw, push, push_vld_d;
  logic [PW-1:0] wr_idx, rd_idx;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [DW-1:0] ld_ext, wdata_d;
  logic          qp;

  // Extra pointer MSB separates full from empty at equal indices.
  assign occ    = wr_ptr_q - rd_ptr_q;
  assign full   = (occ == (PW+1)'(QDEPTH));
  assign empty  = (occ == '0);
  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];

  assign pw   = bus.wb_valid & bus.wb_regwrite & (bus.wb_waddr != '0);
  assign push = bus.late_valid & ~full;
  // $0 targets and results already superseded by this cycle's pipeline
  // write are accepted but parked invalid so they can never be written.
  assign push_vld_d = (bus.late_waddr != '0) &
                      ~(pw & (bus.late_waddr == bus.wb_waddr));

  // Little-endian lane extraction; half ignores boff[0].
  assign ld_b = bus.wb_mem[8*bus.wb_boff +: 8];
  assign ld_h = bus.wb_mem[16*bus.wb_boff[1] +: 16];

  always_comb begin
    ld_ext = bus.wb_mem;
    case (bus.wb_size)
      2'b00:   ld_ext = bus.wb_unsigned ? {{(DW-8){1'b0}}, ld_b}
                                        : {{(DW-8){ld_b[7]}}, ld_b};
      2'b01:   ld_ext = bus.wb_unsigned ? {{(DW-16){1'b0}}, ld_h}
                                        : {{(DW-16){ld_h[15]}}, ld_h};
      default: ld_ext = bus.wb_mem;
    endcase
  end

  assign wdata_d = bus.wb_memtoreg ? ld_ext : bus.wb_alu;

  // Popped entries have their valid cleared, so every set valid bit is a
  // live, still-to-be-written result.
  always_comb begin
    qp = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      if (q_vld_q[i] && q_addr_q[i] == bus.query_addr) qp = 1'b1;
    if (bus.query_addr == '0) qp = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_vld_q[i]  <= 1'b0;
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      if (pw) begin
        we_q    <= 1'b1;
        waddr_q <= bus.wb_waddr;
        wdata_q <= wdata_d;
        // Younger pipeline write supersedes any queued result to same reg.
        for (int i = 0; i < QDEPTH; i++)
          if (q_vld_q[i] && q_addr_q[i] == bus.wb_waddr) q_vld_q[i] <= 1'b0;
      end else if (!empty) begin
        // Invalidated head still pops, as a bubble.
        we_q <= q_vld_q[rd_idx];
        if (q_vld_q[rd_idx]) begin
          waddr_q <= q_addr_q[rd_idx];
          wdata_q <= q_data_q[rd_idx];
        end
        q_vld_q[rd_idx] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + (PW+1)'(1);
      end else begin
        we_q <= 1'b0;
      end
      // Push slot is never the popped one: push needs !full.
      if (push) begin
        q_vld_q[wr_idx]  <= push_vld_d;
        q_addr_q[wr_idx] <= bus.late_waddr;
        q_data_q[wr_idx] <= bus.late_data;
        wr_ptr_q         <= wr_ptr_q + (PW+1)'(1);
      end
    end
  end

  assign bus.late_ready    = ~full;
  assign bus.query_pending = qp;
  assign bus.WriteReg      = we_q;
  assign bus.wAddr         = waddr_q;
  assign bus.wData         = wdata_q;
endmodule
